pw_pattern_match: RTL and testbench
===================================

PW_PATTERN_MATCH -- requirements
Module: pw_pattern_match

Interface
REQ-001 Parameter: pPATTERN_BYTES, default 8, maximum pattern length in bytes (N).
REQ-002 fe_clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 I_arm  input  1  arm level from register block; rising edge arms, low disarms.
REQ-005 I_pattern  input  8*N  pattern; byte k at bits [8k+7:8k].
REQ-006 I_mask  input  8*N  per-bit compare enable; 1 = compare, 0 = don't care.
REQ-007 I_pattern_bytes  input  4  active pattern length, 0..15.
REQ-008 I_data  input  8  captured front-end byte.
REQ-009 I_data_valid  input  1  qualifies I_data for one cycle.
REQ-010 O_match  output  1  single-cycle match pulse to the downstream trigger generator.
REQ-011 O_armed  output  1  high while the block is in state ARMED.
REQ-012 O_match_count  output  8  number of matches since reset; saturates at 255.

Function
REQ-013 States: IDLE, ARMED, DONE, encoded in a registered state machine.
REQ-014 IDLE -> ARMED on the edge where I_arm=1 and I_arm was 0 on the previous edge; I_arm held high through reset does not arm.
REQ-015 On entry to ARMED: history shift register cleared to 0; byte counter cleared to 0.
REQ-016 In ARMED, each edge with I_data_valid=1 shifts I_data into history byte 0; byte k moves to byte k+1; byte N-1 is discarded.
REQ-017 Byte counter increments per accepted byte and saturates at N.
REQ-018 Effective length L = min(I_pattern_bytes, N); L=0 never matches.
REQ-019 Match condition: byte counter >= L, and for every k < L, (history byte k XOR pattern byte k) AND mask byte k == 0; bytes k >= L are ignored.
REQ-020 Pattern byte 0 compares against the most recently received byte; pattern byte k compares against the byte received k bytes earlier.
REQ-021 The match condition is evaluated only in the cycle following a shift; no new byte means no evaluation.
REQ-022 Latency: byte sampled at edge E; O_match=1 from edge E+1 to edge E+2; O_match is never wider than one cycle.
REQ-023 On the edge that asserts O_match, state -> DONE and O_match_count increments unless it is 255.
REQ-024 In DONE: I_data_valid ignored; no further matches; stays in DONE until I_arm=0.
REQ-025 In ARMED or DONE, I_arm=0 on an edge -> IDLE on that edge; disarm overrides a pending match, so O_match stays 0 and the count does not change.
REQ-026 In IDLE, bytes are not shifted and O_match stays 0.
REQ-027 Re-arm requires a new 0 -> 1 transition of I_arm; history and counter are cleared again.
REQ-028 I_pattern, I_mask and I_pattern_bytes are sampled combinationally at evaluation time; software changes them only while disarmed.
REQ-029 Back-to-back I_data_valid (every cycle) is supported with no byte loss.

Reset
REQ-030 With reset_i=1: state=IDLE, history=0, byte counter=0, O_match=0, O_armed=0, O_match_count=0, arm edge detector register=0.
REQ-031 Reset mid-operation (ARMED or DONE) aborts immediately; a pending match pulse is suppressed.

Verification
REQ-032 N=8, L=3, pattern bytes0..2=0x33,0x22,0x11, mask all 1s; arm, then send 0x11,0x22,0x33 on consecutive cycles -> O_match=1 for exactly one cycle, one edge after 0x33 is sampled; O_armed=0; count=1.
REQ-033 Same setup, send 0x11,0x22,0x34 -> no match; then send 0x11,0x22,0x33 -> match; sequence 0x11,0x22,0x11,0x22,0x33 also matches exactly once.
REQ-034 Mask byte0=0xF0, pattern byte0=0xA0, L=1; send 0xA7 -> match; send 0xB0 after re-arm -> no match.
REQ-035 L=4; arm, send only 3 matching-suffix bytes -> no match until the 4th byte; I_pattern_bytes=0 -> 100 random bytes give no match; I_pattern_bytes=15 behaves as L=8.
REQ-036 Drop I_arm on the same edge the completing byte's evaluation would assert O_match -> O_match=0 and count is unchanged; assert reset_i mid-ARMED -> all outputs 0 on the next cycle.
REQ-037 Force count to 255 via 255 arm/match cycles; one more match -> pulse still occurs and O_match_count stays 255.

Source files
------------

// File: rtl/pw_pattern_match_if.sv
// Bus between the register block / capture front end and the pattern matcher.
interface pw_pattern_match_if #(
    parameter int pPATTERN_BYTES = 8
);
    logic                        I_arm;
    logic [8*pPATTERN_BYTES-1:0] I_pattern;
    logic [8*pPATTERN_BYTES-1:0] I_mask;
    logic [3:0]                  I_pattern_bytes;
    logic [7:0]                  I_data;
    logic                        I_data_valid;
    logic                        O_match;
    logic                        O_armed;
    logic [7:0]                  O_match_count;

    modport master (
        output I_arm, I_pattern, I_mask, I_pattern_bytes, I_data, I_data_valid,
        input  O_match, O_armed, O_match_count
    );

    modport slave (
        input  I_arm, I_pattern, I_mask, I_pattern_bytes, I_data, I_data_valid,
        output O_match, O_armed, O_match_count
    );
endinterface

// File: rtl/pw_pattern_match.sv
// Byte-stream pattern matcher: once armed, compares the most recent L captured
// bytes against a masked pattern and fires a one-cycle trigger pulse.
module pw_pattern_match #(
    parameter int pPATTERN_BYTES = 8
) (
    input  logic              fe_clk,
    input  logic              reset_i,
    pw_pattern_match_if.slave bus
);
    localparam int N     = pPATTERN_BYTES;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       hist_q [N];
    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] eff_len;
    logic [7:0]       count_q;
    logic             eval_q;
    logic             match_q;
    logic             match_d;
    logic             arm_low_q;
    logic             arm_rise;
    logic             shift_en;
    logic             clear_en;
    logic             bytes_ok;
    logic             match_hit;

    // arm_low_q is only set by a low level seen outside reset, so an arm
    // level held high through reset cannot look like a rising edge.
    assign arm_rise = bus.I_arm & arm_low_q;
    assign shift_en = (state_q == ARMED) & bus.I_data_valid;

    // Effective length: the 4-bit length field clamped to the history depth.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_len = CNT_W'(N);
        if (int'(bus.I_pattern_bytes) < N) begin
            eff_len = CNT_W'(bus.I_pattern_bytes);
        end
    end

    // Masked byte compare over the active window; bytes beyond L are ignored.
    always_comb begin
        bytes_ok = 1'b1;
        for (int k = 0; k < N; k++) begin
            if ((k < int'(eff_len)) &&
                (((hist_q[k] ^ bus.I_pattern[8*k +: 8]) & bus.I_mask[8*k +: 8]) != 8'd0)) begin
                bytes_ok = 1'b0;
            end
        end
    end

    assign match_hit = (eff_len != '0) && (byte_cnt_q >= eff_len) && bytes_ok;

    // Next-state and match decision; disarm takes priority over a pending match.
    always_comb begin
        state_d  = state_q;
        match_d  = 1'b0;
        clear_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_rise) begin
                    state_d  = ARMED;
                    clear_en = 1'b1;
                end
            end
            ARMED: begin
                if (!bus.I_arm) begin
                    state_d = IDLE;
                end else if (eval_q && match_hit) begin
                    state_d = DONE;
                    match_d = 1'b1;
                end
            end
            DONE: begin
                if (!bus.I_arm) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge fe_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // History shift register, byte counter, match pulse, counter and arm edge detector.
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            // NOTE: the history is a small register file that must read as zero after reset, so it is reset explicitly.
            for (int k = 0; k < N; k++) begin
                hist_q[k] <= 8'd0;
            end
            byte_cnt_q <= '0;
            eval_q     <= 1'b0;
            match_q    <= 1'b0;
            count_q    <= 8'd0;
            arm_low_q  <= 1'b0;
        end else begin
            arm_low_q <= ~bus.I_arm;
            match_q   <= match_d;
            eval_q    <= shift_en;
            if (clear_en) begin
                for (int k = 0; k < N; k++) begin
                    hist_q[k] <= 8'd0;
                end
                byte_cnt_q <= '0;
            end else if (shift_en) begin
                hist_q[0] <= bus.I_data;
                for (int k = 1; k < N; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
                if (byte_cnt_q != CNT_W'(N)) begin
                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                end
            end
            if (match_d && (count_q != 8'hFF)) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.O_match       = match_q;
    assign bus.O_armed       = (state_q == ARMED);
    assign bus.O_match_count = count_q;
endmodule

// File: tb/tb_pw_pattern_match.sv
// Scoreboard bench for pw_pattern_match: a byte-list reference model predicts
// each match pulse (edge and count) into a queue; a monitor pops and compares.
module tb_pw_pattern_match;
    localparam int N = 8;

    logic fe_clk = 1'b0;
    logic reset_i;
    always #5 fe_clk = ~fe_clk;

    pw_pattern_match_if #(.pPATTERN_BYTES(N)) bus ();
    pw_pattern_match #(.pPATTERN_BYTES(N)) dut (
        .fe_clk (fe_clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    always @(posedge fe_clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int edge_no;
        int count;
    } exp_t;
    exp_t sb_q[$];

    typedef enum {M_IDLE, M_ARMED, M_DONE} mode_t;
    mode_t      m_mode;
    logic [7:0] m_rx[$];      // bytes received since arming, newest first
    bit         m_pending;
    bit         m_prev_low;
    int         m_count;

    logic [7:0] pat [N];
    logic [7:0] msk [N];
    int         pat_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < N; k++) begin
            bus.I_pattern[8*k +: 8] = pat[k];
            bus.I_mask[8*k +: 8]    = msk[k];
        end
        bus.I_pattern_bytes = 4'(pat_len);
    endtask

    function automatic bit model_hit();
        int l;
        l = (pat_len > N) ? N : pat_len;
        if (l == 0) return 1'b0;
        if (m_rx.size() < l) return 1'b0;
        for (int k = 0; k < l; k++) begin
            if (((m_rx[k] ^ pat[k]) & msk[k]) != 8'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Behaviour of one clock edge given the inputs presented at it.
    task automatic model_edge(input bit rst, input bit arm, input bit valid, input logic [7:0] data);
        if (rst) begin
            m_mode = M_IDLE;
            m_rx.delete();
            m_pending  = 1'b0;
            m_count    = 0;
            m_prev_low = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (arm && m_prev_low) begin
                    m_mode = M_ARMED;
                    m_rx.delete();
                    m_pending = 1'b0;
                end
            end
            M_ARMED: begin
                if (!arm) begin
                    m_mode    = M_IDLE;
                    m_pending = 1'b0;
                end else begin
                    if (m_pending && model_hit()) begin
                        m_mode = M_DONE;
                        if (m_count < 255) m_count++;
                        sb_q.push_back('{edge_cnt + 1, m_count});
                    end
                    m_pending = valid;
                    if (valid) begin
                        m_rx.push_front(data);
                        if (m_rx.size() > N) void'(m_rx.pop_back());
                    end
                end
            end
            default: begin
                if (!arm) m_mode = M_IDLE;
            end
        endcase
        m_prev_low = !arm;
    endtask

    task automatic step(input bit rst, input bit arm, input bit valid, input logic [7:0] data);
        @(negedge fe_clk);
        reset_i          = rst;
        bus.I_arm        = arm;
        bus.I_data_valid = valid;
        bus.I_data       = data;
        model_edge(rst, arm, valid, data);
        @(posedge fe_clk);
        #1;
        check("armed", 32'(bus.O_armed), 32'(m_mode == M_ARMED));
        check("count", 32'(bus.O_match_count), 32'(m_count));
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic disarm(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic rearm();
        disarm(1);
        step(1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic cfg3();
        for (int k = 0; k < N; k++) begin
            pat[k] = 8'd0;
            msk[k] = 8'hFF;
        end
        pat[0] = 8'h33; pat[1] = 8'h22; pat[2] = 8'h11;
        pat_len = 3;
        apply_cfg();
    endtask

    // Monitor: every asserted O_match must match the head of the scoreboard.
    initial begin
        forever begin
            @(posedge fe_clk);
            #1;
            if (bus.O_match === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL match_unexpected: pulse at edge %0d, none expected", edge_cnt);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("match_edge", 32'(edge_cnt), 32'(e.edge_no));
                    check("match_count", 32'(bus.O_match_count), 32'(e.count));
                end
            end else if (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL match_missing: no pulse at edge %0d, expected at %0d", edge_cnt, sb_q[0].edge_no);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        bus.I_arm = 1'b0;
        bus.I_data_valid = 1'b0;
        bus.I_data = 8'd0;
        for (int k = 0; k < N; k++) begin
            pat[k] = 8'd0;
            msk[k] = 8'd0;
        end
        pat_len = 0;
        apply_cfg();
        model_edge(1'b1, 1'b0, 1'b0, 8'd0);

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("rst_match", 32'(bus.O_match), 32'd0);
        check("rst_armed", 32'(bus.O_armed), 32'd0);
        check("rst_count", 32'(bus.O_match_count), 32'd0);
        disarm(2);

        // Basic three-byte match
        cfg3();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("armed_after_arm", 32'(bus.O_armed), 32'd1);
        send(8'h11); send(8'h22); send(8'h33);
        idle(2);
        check("basic_count", 32'(bus.O_match_count), 32'd1);
        check("basic_armed", 32'(bus.O_armed), 32'd0);

        // Near miss, then match, then overlapping prefix
        rearm();
        send(8'h11); send(8'h22); send(8'h34);
        idle(2);
        check("nearmiss_count", 32'(bus.O_match_count), 32'd1);
        send(8'h11); send(8'h22); send(8'h33);
        idle(2);
        check("second_count", 32'(bus.O_match_count), 32'd2);
        rearm();
        send(8'h11); send(8'h22); send(8'h11); send(8'h22); send(8'h33);
        idle(2);
        check("overlap_count", 32'(bus.O_match_count), 32'd3);

        // Partial mask
        disarm(1);
        for (int k = 0; k < N; k++) msk[k] = 8'hFF;
        pat[0] = 8'hA0; msk[0] = 8'hF0; pat_len = 1;
        apply_cfg();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        send(8'hA7);
        idle(2);
        check("mask_hit_count", 32'(bus.O_match_count), 32'd4);
        rearm();
        send(8'hB0);
        idle(2);
        check("mask_miss_count", 32'(bus.O_match_count), 32'd4);

        // Length guard: history zeros must not complete a 4-byte pattern
        disarm(1);
        for (int k = 0; k < N; k++) begin
            pat[k] = 8'd0;
            msk[k] = 8'hFF;
        end
        pat[0] = 8'h33; pat[1] = 8'h22; pat[2] = 8'h11; pat[3] = 8'h00; pat_len = 4;
        apply_cfg();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        send(8'h11); send(8'h22); send(8'h33);
        idle(3);
        check("len4_short_count", 32'(bus.O_match_count), 32'd4);
        rearm();
        send(8'h00); send(8'h11); send(8'h22);
        idle(1);
        check("len4_three_count", 32'(bus.O_match_count), 32'd4);
        send(8'h33);
        idle(2);
        check("len4_full_count", 32'(bus.O_match_count), 32'd5);

        // Zero length never matches
        disarm(1);
        pat_len = 0;
        for (int k = 0; k < N; k++) msk[k] = 8'h00;
        apply_cfg();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 100; i++) send(8'($urandom_range(0, 255)));
        idle(2);
        check("len0_count", 32'(bus.O_match_count), 32'd5);

        // Length 15 clamps to the full 8-byte history
        disarm(1);
        for (int k = 0; k < N; k++) begin
            pat[k] = 8'($urandom_range(0, 255));
            msk[k] = 8'hFF;
        end
        pat_len = 15;
        apply_cfg();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
        for (int k = N - 1; k >= 0; k--) send(pat[k]);
        idle(2);
        check("len15_count", 32'(bus.O_match_count), 32'd6);

        // Disarm on the evaluation edge suppresses the pulse
        disarm(1);
        cfg3();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        send(8'h11); send(8'h22); send(8'h33);
        disarm(2);
        check("disarm_count", 32'(bus.O_match_count), 32'd6);
        check("disarm_match", 32'(bus.O_match), 32'd0);

        // Reset on the evaluation edge aborts everything
        step(1'b0, 1'b1, 1'b0, 8'd0);
        send(8'h11); send(8'h22); send(8'h33);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        check("midrst_match", 32'(bus.O_match), 32'd0);
        check("midrst_armed", 32'(bus.O_armed), 32'd0);
        check("midrst_count", 32'(bus.O_match_count), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        disarm(2);

        // Randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            int l;
            disarm(1 + $urandom_range(0, 1));
            pat_len = $urandom_range(0, 15);
            for (int k = 0; k < N; k++) begin
                pat[k] = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 3))
                    0:       msk[k] = 8'h00;
                    1:       msk[k] = 8'($urandom_range(0, 255));
                    default: msk[k] = 8'hFF;
                endcase
            end
            apply_cfg();
            l = (pat_len > N) ? N : pat_len;
            step(1'b0, 1'b1, 1'b0, 8'd0);
            for (int i = 0; i < 12; i++) begin
                bit arm;
                arm = ($urandom_range(0, 29) != 0);
                step(1'b0, arm, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int k = l - 1; k >= 0; k--) send(pat[k]);
            end
            idle(2);
        end

        // Saturate the match counter
        disarm(1);
        for (int k = 0; k < N; k++) begin
            pat[k] = 8'd0;
            msk[k] = 8'h00;
        end
        pat_len = 1;
        apply_cfg();
        for (int i = 0; i < 300 && m_count < 255; i++) begin
            rearm();
            send(8'($urandom_range(0, 255)));
            idle(1);
        end
        check("sat_reach_count", 32'(bus.O_match_count), 32'd255);
        rearm();
        send(8'h5A);
        idle(2);
        check("sat_hold_count", 32'(bus.O_match_count), 32'd255);

        disarm(3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
